// File: rtl/scratch_pad_stream_reader_if.sv
// Bus bundle between the stream reader, the scratch_pad port it feeds from,
// the command source and the stream consumer.
//
// Handshake: on cmd_* and out_* a transfer happens in a cycle where valid and
// ready are both 1 at the rising clock edge. The data is held stable while
// valid=1 and ready=0, and the ready side may raise ready without waiting for
// valid. On the scratch_pad side rd_en is a single-cycle request that is only
// raised while full=0. Each request returns exactly one in-order valid/q beat.
interface scratch_pad_stream_reader_if #(
   parameter int WIDTH       = 64,
   parameter int ADDR_WIDTH  = 12,
   parameter int COUNT_WIDTH = 16
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [ADDR_WIDTH-1:0]  cmd_base;
   logic [COUNT_WIDTH-1:0] cmd_count;
   logic [COUNT_WIDTH-1:0] cmd_stride;
   logic                   sp_rd_en;
   logic [ADDR_WIDTH-1:0]  sp_addr;
   logic                   sp_full;
   logic [WIDTH-1:0]       sp_q;
   logic                   sp_valid;
   logic                   sp_stall;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic                   out_ready;

   // Engine side
   modport slave (
      input  cmd_valid, cmd_base, cmd_count, cmd_stride,
      input  sp_full, sp_q, sp_valid, out_ready,
      output cmd_ready, sp_rd_en, sp_addr, sp_stall, out_valid, out_data
   );

   // Environment side: command source, scratch_pad port and consumer
   modport master (
      output cmd_valid, cmd_base, cmd_count, cmd_stride,
      output sp_full, sp_q, sp_valid, out_ready,
      input  cmd_ready, sp_rd_en, sp_addr, sp_stall, out_valid, out_data
   );
endinterface

// File: rtl/scratch_pad_stream_reader.sv
// Strided block-read engine for one scratch_pad port. It issues reads under a
// credit limit equal to the response FIFO depth, so every response it asks for
// always has a FIFO slot waiting. It then streams the FIFO out first-word-fall-through.
module scratch_pad_stream_reader #(
   parameter int WIDTH       = 64,
   parameter int ADDR_WIDTH  = 12,
   parameter int COUNT_WIDTH = 16,   // must be >= ADDR_WIDTH
   parameter int FIFO_DEPTH  = 32    // power of 2, >= 2
) (
   input  logic                        clk,
   input  logic                        rst,
   scratch_pad_stream_reader_if.slave  bus,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [1:0]                  dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   DEPTH_CNT    = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW+1:0] DEPTH_CREDIT = (PW+2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [ADDR_WIDTH-1:0]  stride_q;      // only the low bits matter: addresses wrap
   logic [COUNT_WIDTH-1:0] remaining_q;
   logic [PW:0]            outstanding_q;
   logic [PW:0]            wr_ptr_q, rd_ptr_q, fifo_count;
   logic [WIDTH-1:0]       fifo_mem [FIFO_DEPTH];
   logic [PW+1:0]          credit_used;
   logic                   fifo_full, fifo_empty;
   logic                   accept, issue, resp_ok, push, pop;

   assign fifo_count  = wr_ptr_q - rd_ptr_q;
   assign fifo_full   = (fifo_count == DEPTH_CNT);
   assign fifo_empty  = (fifo_count == '0);
   // Credits in use: requests in flight plus words already parked in the FIFO.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

   assign accept  = bus.cmd_valid && (state_q == IDLE);
   assign issue   = (state_q == ISSUE) && (remaining_q != '0) && !bus.sp_full &&
                    (credit_used < DEPTH_CREDIT);
   assign resp_ok = bus.sp_valid && (outstanding_q != '0);
   assign pop     = !fifo_empty && bus.out_ready;
   assign push    = resp_ok && (!fifo_full || pop);

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.sp_rd_en  = issue;
   assign bus.sp_addr   = addr_q;
   assign bus.sp_stall  = fifo_full;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = fifo_mem[rd_ptr_q[PW-1:0]];
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DRAIN) && (outstanding_q == '0);
   assign dbg_state     = state_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: issue until nothing remains, then wait for all responses
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (remaining_q == '0) state_d = DRAIN;
         DRAIN:   if (outstanding_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Command registers: latch on accept, then step the address and count per issue
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
      end else if (accept) begin
         addr_q      <= bus.cmd_base;
         stride_q    <= bus.cmd_stride[ADDR_WIDTH-1:0];
         remaining_q <= bus.cmd_count;
      end else if (issue) begin
         addr_q      <= addr_q + stride_q;
         remaining_q <= remaining_q - 1'b1;
      end
   end

   // In-flight read counter: up on issue, down on an expected response
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
      end else begin
         case ({issue, resp_ok})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   // Sticky error: unsolicited response, or a response with nowhere to go
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if ((bus.sp_valid && (outstanding_q == '0)) || (resp_ok && fifo_full && !pop))
         err <= 1'b1;
   end

   // FIFO pointers; the extra MSB separates full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage: data needs no reset, the pointers qualify it
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= bus.sp_q;
   end
endmodule

// File: tb/tb_scratch_pad_stream_reader.sv
// Bench for scratch_pad_stream_reader: scratch_pad port model with in-order
// variable latency, command driver, per-cycle behavioural model and a golden
// stream of expected words derived from base/count/stride.
module tb_scratch_pad_stream_reader;
   localparam int WIDTH = 64;
   localparam int AW    = 12;
   localparam int CW    = 16;
   localparam int FD    = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scratch_pad_stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus();
   logic       busy, done, err;
   logic [1:0] dbg_state;

   scratch_pad_stream_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW),
                               .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   // ---------------- bench state ----------------
   int tests_run = 0;
   int fails     = 0;
   int cyc       = 0;

   logic [WIDTH-1:0] mem [4096];
   logic [WIDTH-1:0] exp_q [$];    // golden output stream
   logic [WIDTH-1:0] fifo_m [$];   // words the engine should be holding

   typedef struct { int due; logic [WIDTH-1:0] data; } resp_t;
   resp_t resp_q [$];
   int    last_due = 0;

   // behavioural model
   int          m_phase = 0;   // 0 idle, 1 issuing, 2 waiting for responses
   int          m_left  = 0;
   logic [AW-1:0] m_addr = '0;
   logic [AW-1:0] m_stride = '0;
   int          m_out   = 0;
   bit          m_err   = 0;

   // stimulus knobs
   int ready_mode = 1;          // 0 hold low, 1 hold high, 2 random
   bit full_rand  = 0;
   bit full_force = 0;
   int lat_min = 3, lat_max = 3;
   bit inject = 0;

   // logs
   logic [AW-1:0] iss_log [$];
   int iss_cyc [$];
   int done_cnt = 0, done_cyc = -1, acc_cyc = -1, ready_cyc = -1;
   bit ready_pending = 0;
   int pop_cnt = 0, full_issue_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests_run++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- scratch_pad port model / input driver ----------------
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      bus.sp_full = full_force || (full_rand && ($urandom_range(0, 3) == 0));
      case (ready_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.sp_q = {$urandom, $urandom};
      if (inject) begin
         bus.sp_valid = 1'b1;
      end else if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
         bus.sp_valid = 1'b1;
         bus.sp_q     = resp_q[0].data;
         void'(resp_q.pop_front());
      end else begin
         bus.sp_valid = 1'b0;
      end
   end

   // ---------------- model + compare, once per cycle ----------------
   always @(negedge clk) begin : model
      bit exp_rd, exp_ov, exp_pop, took;
      int pre_size, pre_out, a;
      if (rst) begin
         m_phase = 0; m_left = 0; m_out = 0; m_err = 0;
         fifo_m.delete(); exp_q.delete(); resp_q.delete();
         last_due = 0;
      end else begin
         pre_size = fifo_m.size();
         pre_out  = m_out;
         exp_ov   = (pre_size != 0);
         exp_rd   = (m_phase == 1) && (m_left > 0) && !bus.sp_full && ((pre_out + pre_size) < FD);

         check("cmd_ready", 64'(bus.cmd_ready), 64'(m_phase == 0));
         check("busy", 64'(busy), 64'(m_phase != 0));
         check("sp_rd_en", 64'(bus.sp_rd_en), 64'(exp_rd));
         if (exp_rd && bus.sp_rd_en) check("sp_addr", 64'(bus.sp_addr), 64'(m_addr));
         check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
         if (exp_ov) check("out_data", bus.out_data, fifo_m[0]);
         check("sp_stall", 64'(bus.sp_stall), 64'(pre_size == FD));
         check("done", 64'(done), 64'((m_phase == 2) && (pre_out == 0)));
         check("err", 64'(err), 64'(m_err));

         // scratch_pad answers what it actually sees
         if (bus.sp_rd_en) begin
            a = cyc + $urandom_range(lat_min, lat_max);
            if (a <= last_due) a = last_due + 1;
            last_due = a;
            resp_q.push_back('{due: a, data: mem[bus.sp_addr]});
            iss_log.push_back(bus.sp_addr);
            iss_cyc.push_back(cyc);
            if (bus.sp_full) full_issue_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (ready_pending && bus.cmd_ready) begin
            ready_cyc = cyc;
            ready_pending = 0;
         end

         // consumer side
         exp_pop = exp_ov && bus.out_ready;
         if (bus.out_valid && bus.out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) check("stream_extra", bus.out_data, 64'hx);
            else                   check("stream", bus.out_data, exp_q.pop_front());
         end
         if (exp_pop) void'(fifo_m.pop_front());

         // response side
         took = 0;
         if (bus.sp_valid) begin
            if (pre_out == 0) m_err = 1;
            else begin
               took = 1;
               if (pre_size < FD || exp_pop) fifo_m.push_back(bus.sp_q);
               else m_err = 1;
            end
         end
         m_out = pre_out + (exp_rd ? 1 : 0) - (took ? 1 : 0);

         // command progress
         case (m_phase)
            0: if (bus.cmd_valid) begin
                  m_phase  = 1;
                  m_left   = int'(bus.cmd_count);
                  m_addr   = bus.cmd_base;
                  m_stride = bus.cmd_stride[AW-1:0];
                  acc_cyc  = cyc;
                  ready_pending = 1;
                  for (int i = 0; i < int'(bus.cmd_count); i++) begin
                     a = (int'(bus.cmd_base) + i * int'(bus.cmd_stride)) % 4096;
                     exp_q.push_back(mem[a]);
                  end
               end
            1: if (m_left == 0) m_phase = 2;
               else if (exp_rd) begin
                  m_addr = m_addr + m_stride;
                  m_left--;
               end
            default: if (pre_out == 0) m_phase = 0;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [AW-1:0] base, input int count, input int stride);
      bit got = 0;
      @(posedge clk); #2;
      bus.cmd_valid  = 1'b1;
      bus.cmd_base   = base;
      bus.cmd_count  = CW'(count);
      bus.cmd_stride = CW'(stride);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin got = 1; break; end
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      bus.cmd_valid = 1'b0;
      if (!got) check("cmd_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (m_phase == 0 && exp_q.size() == 0 && resp_q.size() == 0) begin ok = 1; break; end
      end
      if (!ok) check("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic clear_logs();
      iss_log.delete(); iss_cyc.delete();
      done_cnt = 0; done_cyc = -1; pop_cnt = 0; full_issue_cnt = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
      bus.cmd_valid = 0; bus.cmd_base = '0; bus.cmd_count = '0; bus.cmd_stride = '0;
      bus.sp_full = 0; bus.sp_q = '0; bus.sp_valid = 0; bus.out_ready = 1;

      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst_sp_rd_en", 64'(bus.sp_rd_en), 64'd0);
      check("rst_sp_addr", 64'(bus.sp_addr), 64'd0);
      check("rst_sp_stall", 64'(bus.sp_stall), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      // 1: simple contiguous read, fixed latency 3
      clear_logs();
      send_cmd(12'h010, 4, 1);
      wait_idle();
      check("t1_issues", 64'(iss_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < iss_log.size(); i++) begin
         check("t1_addr", 64'(iss_log[i]), 64'(12'h010 + i));
         check("t1_consecutive", 64'(iss_cyc[i]), 64'(iss_cyc[0] + i));
      end
      check("t1_pops", 64'(pop_cnt), 64'd4);
      check("t1_done_cnt", 64'(done_cnt), 64'd1);
      check("t1_err", 64'(err), 64'd0);

      // 2: address wrap
      clear_logs();
      send_cmd(12'hFFE, 3, 3);
      wait_idle();
      check("t2_issues", 64'(iss_log.size()), 64'd3);
      if (iss_log.size() == 3) begin
         check("t2_addr0", 64'(iss_log[0]), 64'h0FFE);
         check("t2_addr1", 64'(iss_log[1]), 64'h0001);
         check("t2_addr2", 64'(iss_log[2]), 64'h0004);
      end
      check("t2_pops", 64'(pop_cnt), 64'd3);

      // 3: credit limit with a stalled consumer
      clear_logs();
      ready_mode = 0;
      send_cmd(12'h300, 40, 1);
      cycles(80);
      check("t3_issues_halted", 64'(iss_log.size()), 64'd32);
      check("t3_no_done_yet", 64'(done_cnt), 64'd0);
      ready_mode = 1;
      wait_idle();
      check("t3_issues_total", 64'(iss_log.size()), 64'd40);
      check("t3_pops", 64'(pop_cnt), 64'd40);
      check("t3_done_cnt", 64'(done_cnt), 64'd1);

      // 4: port full for 5 cycles mid-command
      clear_logs();
      send_cmd(12'h100, 12, 2);
      for (int i = 0; i < 100 && iss_log.size() < 3; i++) @(negedge clk);
      @(posedge clk); #2;
      full_force = 1;
      cycles(5);
      full_force = 0;
      wait_idle();
      check("t4_issue_while_full", 64'(full_issue_cnt), 64'd0);
      check("t4_issues", 64'(iss_log.size()), 64'd12);
      for (int i = 0; i < iss_log.size(); i++)
         check("t4_addr", 64'(iss_log[i]), 64'(12'h100 + 2 * i));

      // 5: zero-length command
      clear_logs();
      send_cmd(12'h200, 0, 5);
      wait_idle();
      cycles(2);
      check("t5_issues", 64'(iss_log.size()), 64'd0);
      check("t5_done_cnt", 64'(done_cnt), 64'd1);
      check("t5_done_at_T2", 64'(done_cyc - acc_cyc), 64'd2);
      check("t5_ready_at_T3", 64'(ready_cyc - acc_cyc), 64'd3);

      // random commands, random backpressure and latency
      ready_mode = 2; full_rand = 1; lat_min = 1; lat_max = 6;
      for (int n = 0; n < 15; n++) begin
         send_cmd(AW'($urandom_range(0, 4095)), $urandom_range(0, 45), $urandom_range(0, 65535));
         wait_idle();
      end
      ready_mode = 1; full_rand = 0;
      cycles(40);
      check("rand_err", 64'(err), 64'd0);

      // 6: reset mid-issue, then an unsolicited response
      ready_mode = 0; lat_min = 12; lat_max = 12;
      send_cmd(12'h040, 20, 1);
      for (int i = 0; i < 100 && m_out < 5; i++) @(negedge clk);
      check("t6_outstanding_reached", 64'(m_out >= 5), 64'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_out_valid", 64'(bus.out_valid), 64'd0);
      check("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk); #2;
      inject = 1;
      @(posedge clk); #2;
      inject = 0;
      @(posedge clk);
      @(negedge clk);
      check("t6_err", 64'(err), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
